// File: rtl/codec_map_dec_input_buffer.sv
// Ping-pong input buffer for the MAP decoder: one banked write port fills one half while
// cNRD crossbar read ports read the other half; frame handshake passes ownership and a tag.
module codec_map_dec_input_buffer #(
  parameter int pDATA_W   = 32,
  parameter int pADDR_W   = 8,
  parameter int pNRD_LOG2 = 1,
  parameter int pTAG_W    = 4,
  parameter int pDPIPE    = 0
) (
  input  logic                                 iclk,
  input  logic                                 ireset,
  input  logic                                 iclkena,
  input  logic                                 iwrite,
  input  logic [pADDR_W-1:0]                   iwaddr,
  input  logic [pDATA_W-1:0]                   iwdata,
  input  logic                                 iwfull,
  input  logic [pTAG_W-1:0]                    iwtag,
  output logic                                 owfull,
  input  logic                                 iread,
  input  logic [(2**pNRD_LOG2)*pADDR_W-1:0]    iraddr,
  input  logic                                 irempty,
  output logic                                 orfull,
  output logic [pTAG_W-1:0]                    ortag,
  output logic                                 orval,
  output logic [(2**pNRD_LOG2)*pDATA_W-1:0]    ordata,
  output logic                                 oconflict
);

  localparam int cNRD  = 2**pNRD_LOG2;
  localparam int cWA_W = pADDR_W - pNRD_LOG2;
  localparam int cDEPTH = 2**(cWA_W + 1);

  // Each bank holds both halves; the top word-address bit selects the half.
  logic [pDATA_W-1:0] mem [cNRD][cDEPTH];

  logic              wbuf_q, wbuf_d;
  logic              rbuf_q, rbuf_d;
  logic [1:0]        used_q, used_d;
  logic [pTAG_W-1:0] tag_q [2];
  logic [pTAG_W-1:0] tag_d [2];
  logic              owfull_q, owfull_d;
  logic              acc_w, acc_r;

  always_comb begin
    acc_w    = iclkena && iwfull  && (used_q != 2'd2);
    acc_r    = iclkena && irempty && (used_q != 2'd0);
    wbuf_d   = wbuf_q ^ acc_w;
    rbuf_d   = rbuf_q ^ acc_r;
    used_d   = used_q + {1'b0, acc_w} - {1'b0, acc_r};
    tag_d[0] = tag_q[0];
    tag_d[1] = tag_q[1];
    if (acc_w) tag_d[wbuf_q] = iwtag;
    owfull_d = (used_d == 2'd2);
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      wbuf_q   <= 1'b0;
      rbuf_q   <= 1'b0;
      used_q   <= 2'd0;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
      owfull_q <= 1'b0;
    end else begin
      wbuf_q   <= wbuf_d;
      rbuf_q   <= rbuf_d;
      used_q   <= used_d;
      tag_q[0] <= tag_d[0];
      tag_q[1] <= tag_d[1];
      owfull_q <= owfull_d;
    end
  end

  assign owfull = owfull_q;
  assign orfull = (used_q != 2'd0);
  assign ortag  = tag_q[rbuf_q];

  logic                 wr_en;
  logic [pNRD_LOG2-1:0] wr_bank;
  logic [cWA_W-1:0]     wr_word;

  assign wr_en   = iclkena && iwrite && !owfull_q;
  assign wr_bank = iwaddr[pNRD_LOG2-1:0];
  assign wr_word = iwaddr[pADDR_W-1:pNRD_LOG2];

  always_ff @(posedge iclk) begin
    if (wr_en) mem[wr_bank][{wbuf_q, wr_word}] <= iwdata;
  end

  logic [pNRD_LOG2-1:0]      port_bank [cNRD];
  logic [cWA_W-1:0]          port_word [cNRD];
  logic [cWA_W-1:0]          bank_word [cNRD];
  logic [pDATA_W-1:0]        bank_data [cNRD];
  logic [cNRD*pDATA_W-1:0]   xbar_data;
  logic                      conflict;

  // Descending scan so the lowest-index port claiming a bank wins its address.
  always_comb begin
    for (int p = 0; p < cNRD; p++) begin
      port_bank[p] = iraddr[p*pADDR_W +: pNRD_LOG2];
      port_word[p] = iraddr[p*pADDR_W + pNRD_LOG2 +: cWA_W];
    end
    for (int b = 0; b < cNRD; b++) begin
      bank_word[b] = '0;
      for (int p = cNRD - 1; p >= 0; p--) begin
        if (port_bank[p] == pNRD_LOG2'(b)) bank_word[b] = port_word[p];
      end
      bank_data[b] = mem[b][{rbuf_q, bank_word[b]}];
    end
    xbar_data = '0;
    conflict  = 1'b0;
    for (int p = 0; p < cNRD; p++) begin
      xbar_data[p*pDATA_W +: pDATA_W] = bank_data[port_bank[p]];
      for (int q = p + 1; q < cNRD; q++) begin
        if (port_bank[p] == port_bank[q]) conflict = 1'b1;
      end
    end
  end

  logic                    val1_q, val1_d;
  logic                    conf1_q, conf1_d;
  logic [cNRD*pDATA_W-1:0] rd1_q, rd1_d;

  always_comb begin
    val1_d  = val1_q;
    conf1_d = conf1_q;
    rd1_d   = rd1_q;
    if (iclkena) val1_d = iread;
    if (iclkena && iread) begin
      conf1_d = conflict;
      rd1_d   = xbar_data;
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      val1_q  <= 1'b0;
      conf1_q <= 1'b0;
      rd1_q   <= '0;
    end else begin
      val1_q  <= val1_d;
      conf1_q <= conf1_d;
      rd1_q   <= rd1_d;
    end
  end

  generate
    if (pDPIPE != 0) begin : g_dpipe
      logic                    val2_q, val2_d;
      logic                    conf2_q, conf2_d;
      logic [cNRD*pDATA_W-1:0] rd2_q, rd2_d;

      always_comb begin
        val2_d  = val2_q;
        conf2_d = conf2_q;
        rd2_d   = rd2_q;
        if (iclkena) val2_d = val1_q;
        if (iclkena && val1_q) begin
          conf2_d = conf1_q;
          rd2_d   = rd1_q;
        end
      end

      always_ff @(posedge iclk) begin
        if (ireset) begin
          val2_q  <= 1'b0;
          conf2_q <= 1'b0;
          rd2_q   <= '0;
        end else begin
          val2_q  <= val2_d;
          conf2_q <= conf2_d;
          rd2_q   <= rd2_d;
        end
      end

      assign orval     = val2_q;
      assign oconflict = conf2_q;
      assign ordata    = rd2_q;
    end else begin : g_nopipe
      assign orval     = val1_q;
      assign oconflict = conf1_q;
      assign ordata    = rd1_q;
    end
  endgenerate

endmodule
